// File: rtl/universal_register.sv
// WIDTH-bit multi-mode register: hold, load, per-bit JK, shift, rotate and
// up/down count, with serial and terminal-count outputs for cascading.
module universal_register #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
  input  logic             CLK,
  input  logic             CLEAR,
  input  logic             PRESET,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             SER_IN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_BAR,
  output logic             SER_OUT_L,
  output logic             SER_OUT_R,
  output logic             TC
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic             tc_s;

  // Characteristic equation of a JK cell, applied to every bit at once.
  function automatic logic [WIDTH-1:0] jk_next(
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] j,
    input logic [WIDTH-1:0] k
  );
    return (j & ~q) | (~k & q);
  endfunction

  // Next-state selection for the enabled MODE operations.
  always_comb begin
    q_next_s = q_r;
    case (MODE)
      3'd0:    q_next_s = q_r;
      3'd1:    q_next_s = D;
      3'd2:    q_next_s = jk_next(q_r, J, K);
      3'd3:    q_next_s = {q_r[WIDTH-2:0], SER_IN};
      3'd4:    q_next_s = {SER_IN, q_r[WIDTH-1:1]};
      3'd5:    q_next_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
      3'd6:    q_next_s = q_r + ONE;
      3'd7:    q_next_s = q_r - ONE;
      default: q_next_s = q_r;
    endcase
  end

  // Terminal count is ungated by EN so a following stage can use it as enable.
  always_comb begin
    tc_s = 1'b0;
    case (MODE)
      3'd6:    tc_s = (q_r == ALL_ONES);
      3'd7:    tc_s = (q_r == ALL_ZERO);
      default: tc_s = 1'b0;
    endcase
  end

  // The only storage: CLEAR is asynchronous, then PRESET, then EN.
  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) begin
      q_r <= RESET_VALUE;
    end else if (!PRESET) begin
      q_r <= PRESET_VALUE;
    end else if (EN) begin
      q_r <= q_next_s;
    end else begin
      q_r <= q_r;
    end
  end

  assign Q         = q_r;
  assign Q_BAR     = ~q_r;
  assign SER_OUT_L = q_r[WIDTH-1];
  assign SER_OUT_R = q_r[0];
  assign TC        = tc_s;

endmodule
